// File: rtl/conv_pkg.sv
// Shared types and sizes for the convolution tile sequencer slice.
package conv_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int MAT_ELEMS  = 16;
  localparam int KER_ELEMS  = 9;
  localparam int OUT_ELEMS  = 4;
  localparam int LOAD_ELEMS = MAT_ELEMS + KER_ELEMS;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/conv_tile_sequencer_if.sv
// Host-side byte streams of the tile sequencer: input bytes in, result bytes out.
// Handshake: a byte moves on a rising edge where valid && ready; valid never waits on ready, and data holds while valid && !ready.
interface conv_tile_sequencer_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_last
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_last
  );

endinterface

// File: rtl/conv_result_serializer.sv
// Holds the four captured PE results and streams them out as 11, 12, 21, 22 while drain is high.
module conv_result_serializer
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture,
  input  logic [OUT_ELEMS*DATA_W-1:0] capture_data,
  input  logic                        drain,
  input  logic                        res_ready,
  output logic                        res_valid,
  output logic [DATA_W-1:0]           res_data,
  output logic                        res_last,
  output logic                        drain_done
);

  localparam int IDX_W = $clog2(OUT_ELEMS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_ELEMS - 1);

  logic [DATA_W-1:0] res_q [OUT_ELEMS];
  logic [IDX_W-1:0]  idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OUT_ELEMS; i++) res_q[i] <= '0;
      idx_q <= '0;
    end else begin
      if (capture) begin
        for (int i = 0; i < OUT_ELEMS; i++) res_q[i] <= capture_data[i*DATA_W +: DATA_W];
        idx_q <= '0;
      end else if (drain && res_ready) begin
        // wraps to 0 after the last element, ready for the next tile
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign res_valid  = drain;
  assign res_data   = drain ? res_q[idx_q] : '0;
  assign res_last   = drain && (idx_q == IDX_LAST);
  assign drain_done = drain && res_ready && (idx_q == IDX_LAST);

endmodule

// File: rtl/conv_tile_sequencer.sv
// Loads a 4x4 tile and 3x3 kernel from a byte stream, restarts the PE, waits for done and streams the 2x2 result.
// Optional watchdog on the PE done wait: define CONV_SEQ_WATCHDOG_EN.
module conv_tile_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int KICK_CYC    = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  conv_tile_sequencer_if.slave        bus,
  output logic                        busy,
  output logic [MAT_ELEMS*DATA_W-1:0] pe_mat,
  output logic [KER_ELEMS*DATA_W-1:0] pe_kernel,
  output logic                        pe_rst,
  input  logic                        pe_done,
  input  logic [OUT_ELEMS*DATA_W-1:0] pe_conv,
  output logic                        err,
  output seq_state_t                  dbg_state
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [4:0]        LAST_BYTE = 5'(LOAD_ELEMS - 1);
  localparam logic [3:0]        KICK_LAST = 4'(KICK_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(TIMEOUT_CYC);

  seq_state_t                  state_q, state_d;
  logic [4:0]                  load_cnt;
  logic [3:0]                  kick_cnt;
  logic [WAIT_W-1:0]           wait_cnt;
  logic                        accept;
  logic                        capture;
  logic                        timeout;
  logic                        draining;
  logic                        drain_done;
  logic                        wait_armed;
  logic [OUT_ELEMS*DATA_W-1:0] capture_data;

  // A done seen in the very first WAIT cycle may be left over from the previous run.
  assign wait_armed = (wait_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    pe_rst       = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      LOAD: begin
        bus.in_ready = rst;
        pe_rst       = 1'b1;
        accept       = bus.in_valid && rst;
        if (accept && (load_cnt == LAST_BYTE)) state_d = KICK;
      end
      KICK: begin
        pe_rst = 1'b1;
        if (kick_cnt == KICK_LAST) state_d = WAIT;
      end
      WAIT: begin
        if (pe_done && wait_armed) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
`ifdef CONV_SEQ_WATCHDOG_EN
        else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
          timeout = 1'b1;
          capture = 1'b1;
          state_d = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (drain_done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= '0;
      kick_cnt  <= '0;
      wait_cnt  <= '0;
      pe_mat    <= '0;
      pe_kernel <= '0;
    end else begin
      if (accept) begin
        load_cnt <= (load_cnt == LAST_BYTE) ? 5'd0 : load_cnt + 5'd1;
        for (int i = 0; i < MAT_ELEMS; i++)
          if (load_cnt == 5'(i)) pe_mat[i*DATA_W +: DATA_W] <= bus.in_data;
        for (int j = 0; j < KER_ELEMS; j++)
          if (load_cnt == 5'(MAT_ELEMS + j)) pe_kernel[j*DATA_W +: DATA_W] <= bus.in_data;
      end
      kick_cnt <= (state_q == KICK) ? kick_cnt + 4'd1 : 4'd0;
      if (state_q != WAIT)         wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef CONV_SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  // A watchdog expiry still emits a full four-byte frame, filled with zeros.
  assign capture_data = timeout ? '0 : pe_conv;
  assign draining     = (state_q == DRAIN);
  assign busy         = (state_q != LOAD) || (load_cnt != 5'd0);
  assign dbg_state    = state_q;

  conv_result_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .capture_data (capture_data),
    .drain        (draining),
    .res_ready    (bus.res_ready),
    .res_valid    (bus.res_valid),
    .res_data     (bus.res_data),
    .res_last     (bus.res_last),
    .drain_done   (drain_done)
  );

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Bench for conv_tile_sequencer: behavioural PE, random tiles, reference convolution model and result scoreboard.
module tb_conv_tile_sequencer;
  import conv_pkg::*;

  localparam int W      = 8;
  localparam int KICK_N = 2;
  localparam int PE_LAT = 5;
`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             busy, pe_rst, pe_done, err;
  logic [16*W-1:0]  pe_mat;
  logic [9*W-1:0]   pe_kernel;
  logic [4*W-1:0]   pe_conv;
  seq_state_t       dbg_state;

  conv_tile_sequencer_if #(.DATA_W(W)) bus ();

  conv_tile_sequencer #(
    .DATA_W(W), .KICK_CYC(KICK_N), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .pe_mat    (pe_mat),
    .pe_kernel (pe_kernel),
    .pe_rst    (pe_rst),
    .pe_done   (pe_done),
    .pe_conv   (pe_conv),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // behavioural PE: done PE_LAT cycles after pe_rst falls, result computed from its inputs
  logic [3:0] pe_cnt = '0;
  bit stale_mode = 1'b0;
  bit pe_dead    = 1'b0;
  logic pe_ok;

  function automatic logic [W-1:0] pe_elem(input logic [16*W-1:0] m, input logic [9*W-1:0] kk, input int k);
    logic [W-1:0] acc;
    int r, c;
    acc = '0;
    r = k / 2;
    c = k % 2;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc = acc + W'(m[((r + i) * 4 + c + j) * W +: W] * kk[(i * 3 + j) * W +: W]);
    return acc;
  endfunction

  always @(posedge clk) begin
    if (pe_rst) pe_cnt <= '0;
    else if (pe_cnt != 4'hF) pe_cnt <= pe_cnt + 4'd1;
  end

  always_comb begin
    pe_ok   = !pe_rst && (pe_cnt >= 4'(PE_LAT)) && !pe_dead;
    pe_done = pe_ok || (stale_mode && (pe_rst || pe_cnt == 4'd0));
    pe_conv = 32'hA5C3_5A3C;
    if (pe_ok)
      for (int k = 0; k < 4; k++) pe_conv[k*W +: W] = pe_elem(pe_mat, pe_kernel, k);
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int tile_m[16];
  int tile_k[9];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference: 3x3 valid convolution over the bytes as sent, output (orow, ocol)
  function automatic logic [W-1:0] ref_conv(input int orow, input int ocol);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += tile_m[(orow + i) * 4 + ocol + j] * tile_k[i * 3 + j];
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] byte_at(input int idx);
    return (idx < 16) ? W'(tile_m[idx]) : W'(tile_k[idx - 16]);
  endfunction

  task automatic random_tile();
    for (int e = 0; e < 16; e++) tile_m[e] = $urandom_range(0, 255);
    for (int e = 0; e < 9; e++)  tile_k[e] = $urandom_range(0, 255);
  endtask

  // driver: load one tile, then collect its four results under a res_ready pattern
  task automatic run_tile(input bit gaps, input int rmode, input bit hold_in, input bit expect_to);
    int idx = 0;
    int cyc = 0;
    int got = 0;
    int rst_hi = 0;
    int exp_lat;
    bit fell = 0, first = 1, pv = 0, pr = 0, bchk = 0;
    logic [W-1:0] pd = '0;
    logic [W-1:0] ev;
    logic [16*W-1:0] exp_mat;
    logic [9*W-1:0]  exp_ker;
    for (int e = 0; e < 16; e++) exp_mat[e*W +: W] = W'(tile_m[e]);
    for (int e = 0; e < 9; e++)  exp_ker[e*W +: W] = W'(tile_k[e]);
    for (int k = 0; k < 4; k++) exp_q.push_back(expect_to ? '0 : ref_conv(k / 2, k % 2));
    exp_lat = expect_to ? KICK_N + 1 + TMO : KICK_N + 2 + PE_LAT;
    bus.res_ready = 1'b0;
    while (idx < 25 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (idx == 1 && !bchk) begin
        check("busy_loading", busy, 1'b1);
        bchk = 1;
      end
      bus.in_valid = !(gaps && $urandom_range(0, 2) == 0);
      bus.in_data  = byte_at(idx);
      if (bus.in_valid && bus.in_ready) idx++;
    end
    check("bytes_accepted", idx, 25);
    for (int n = 1; n <= 600 && got < 4; n++) begin
      @(negedge clk);
      bus.in_valid = hold_in;
      bus.in_data  = 8'hEE;
      case (rmode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = (n % 3 == 1);
        default: bus.res_ready = 1'($urandom_range(0, 1));
      endcase
      if (n == 1) begin
        check("pe_mat", pe_mat, exp_mat);
        check("pe_kernel", pe_kernel, exp_ker);
        check("kick_state", dbg_state, KICK);
      end
      if (!fell) begin
        if (pe_rst) rst_hi++;
        else begin
          fell = 1;
          check("kick_len", rst_hi, KICK_N);
        end
      end
      if (hold_in) check("in_ready_blocked", bus.in_ready, 1'b0);
      if (bus.res_valid) begin
        if (first) begin
          check("first_latency", n, exp_lat);
          check("err_flag", err, expect_to);
          first = 0;
        end
        if (pv && !pr) check("res_hold", bus.res_data, pd);
        if (bus.res_ready) begin
          ev = exp_q.pop_front();
          check("res_data", bus.res_data, ev);
          check("res_last", bus.res_last, got == 3);
          got++;
        end
      end
      pv = bus.res_valid;
      pr = bus.res_ready;
      pd = bus.res_data;
    end
    check("results_drained", got, 4);
    exp_q.delete();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    check("back_to_load", dbg_state, LOAD);
    check("pe_rst_reload", pe_rst, 1'b1);
  endtask

  task automatic partial_then_reset(input int nbytes);
    int idx = 0;
    for (int c = 0; c < 100 && idx < nbytes; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(c + 1);
      if (bus.in_ready) idx++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("partial_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_pe_rst", pe_rst, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_state", dbg_state, LOAD);
    check("midrst_pe_mat", pe_mat, '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_pe_rst", pe_rst, 1'b1);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_last", bus.res_last, 1'b0);
    check("rst_res_data", bus.res_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, LOAD);
    check("rst_pe_mat", pe_mat, '0);
    check("rst_pe_kernel", pe_kernel, '0);
    rst = 1'b1;
    #1;
    check("in_ready_after_rst", bus.in_ready, 1'b1);

    tile_m = '{2, 1, 3, 1, 0, 2, 4, 2, 1, 3, 2, 0, 2, 1, 0, 1};
    tile_k = '{1, 0, 1, 1, 1, 0, 0, 1, 1};
    run_tile(1'b0, 0, 1'b0, 1'b0);
    run_tile(1'b0, 1, 1'b0, 1'b0);
    run_tile(1'b1, 0, 1'b1, 1'b0);

    partial_then_reset(10);
    random_tile();
    run_tile(1'b0, 2, 1'b0, 1'b0);

    stale_mode = 1'b1;
    random_tile();
    run_tile(1'b0, 0, 1'b0, 1'b0);
    stale_mode = 1'b0;

    for (int t = 0; t < 6; t++) begin
      random_tile();
      run_tile(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef CONV_SEQ_WATCHDOG_EN
    pe_dead = 1'b1;
    random_tile();
    run_tile(1'b0, 0, 1'b0, 1'b1);
    check("err_sticky", err, 1'b1);
    pe_dead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("err_cleared", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
